// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle ARM controller.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UND = 2'b11} op_t;
    typedef enum logic [3:0] {
        CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100, CMD_CMP = 4'b1010, CMD_ORR = 4'b1100
    } cmd_t;
    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL
    } cond_t;
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_ORR = 3;
    localparam int ALU_EOR = 4;
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       link_sel;
        logic       fault;
    } ctrl_t;
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction/flag/memory handshake and control bundle between controller and datapath.
interface mc_ctrl_if #(parameter int ALUCTRL_W = 2);
    logic [31:0]          Instr;
    logic [3:0]           ALUFlags;
    logic                 MemReady;
    logic                 MemReq;
    logic                 MemWrite;
    logic                 AdrSrc;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 LinkSel;
    logic                 Fault;
    logic [3:0]           Flags;
    modport master (
        input  Instr, ALUFlags, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, LinkSel, Fault, Flags
    );
    modport slave (
        output Instr, ALUFlags, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, LinkSel, Fault, Flags
    );
endinterface

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against the {N,Z,C,V} flags.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);
    logic n, z, c, v;
    assign {n, z, c, v} = Flags;
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            EQ: CondEx = z;
            NE: CondEx = !z;
            CS: CondEx = c;
            CC: CondEx = !c;
            MI: CondEx = n;
            PL: CondEx = !n;
            VS: CondEx = v;
            VC: CondEx = !v;
            HI: CondEx = c && !z;
            LS: CondEx = !c || z;
            GE: CondEx = n == v;
            LT: CondEx = n != v;
            GT: CondEx = !z && (n == v);
            LE: CondEx = z || (n != v);
            AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM control unit for the shared-memory ARM datapath.
// Define MC_CTRL_BL_EN to enable branch-with-link (Funct[4] in BRANCH writes R14).
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 2,
    parameter int MEM_TIMEOUT = 0
) (
    input logic       CLK,
    input logic       RST,
    mc_ctrl_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 2);

    state_t               state_q, state_d;
    logic [3:0]           flags_q, flags_d;
    logic [CW-1:0]        wait_q, wait_d;
    logic [1:0]           op;
    logic [5:0]           funct;
    logic [3:0]           cmd, rd;
    logic                 cond_ex, alu_ok, is_cmp, mem_wait, timeout, rdy;
    logic [ALUCTRL_W-1:0] alu_ctl, alu_out;
    ctrl_t                c, ctl;
    logic                 unused_bits;

    assign op          = bus.Instr[27:26];
    assign funct       = bus.Instr[25:20];
    assign cmd         = funct[4:1];
    assign rd          = bus.Instr[15:12];
    assign rdy         = bus.MemReady;
    assign is_cmp      = cmd == CMD_CMP;
    assign unused_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

    cond_check u_cond (.Cond(bus.Instr[31:28]), .Flags(flags_q), .CondEx(cond_ex));

    always_comb begin
        alu_ok  = 1'b1;
        alu_ctl = ALUCTRL_W'(ALU_ADD);
        case (cmd)
            CMD_ADD: alu_ctl = ALUCTRL_W'(ALU_ADD);
            CMD_SUB, CMD_CMP: alu_ctl = ALUCTRL_W'(ALU_SUB);
            CMD_AND: alu_ctl = ALUCTRL_W'(ALU_AND);
            CMD_ORR: alu_ctl = ALUCTRL_W'(ALU_ORR);
            CMD_EOR: begin
                alu_ok  = ALUCTRL_W >= 3;
                alu_ctl = ALUCTRL_W >= 3 ? ALUCTRL_W'(ALU_EOR) : ALUCTRL_W'(ALU_ADD);
            end
            default: alu_ok = 1'b0;
        endcase
    end

    // Ready on the same cycle as the timeout always wins, since a wait needs !MemReady.
    assign mem_wait = (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE) && !rdy;
    assign timeout  = MEM_TIMEOUT != 0 && mem_wait && wait_q == CW'(MEM_TIMEOUT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            flags_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = rdy ? DECODE : FETCH;
            DECODE:   state_d = !cond_ex ? FETCH : op == OP_DP ? (funct[5] ? EXECI : EXECR) :
                                op == OP_MEM ? MEMADR : op == OP_BR ? BRANCH : FETCH;
            EXECR, EXECI: state_d = alu_ok ? ALUWB : FETCH;
            MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = rdy ? MEMWB : timeout ? FETCH : MEMREAD;
            MEMWRITE: state_d = rdy || timeout ? FETCH : MEMWRITE;
            default:  state_d = FETCH;
        endcase
    end

    assign flags_d = (state_q == EXECR || state_q == EXECI) && alu_ok && funct[0] ? bus.ALUFlags : flags_q;
    // A FETCH timeout stays in FETCH, so the retry needs an explicit clear.
    assign wait_d  = !mem_wait || timeout || state_d != state_q ? '0 : wait_q + CW'(1);

    always_comb begin
        c       = '0;
        alu_out = '0;
        case (state_q)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.ir_write   = rdy;
                c.pc_write   = rdy;
                c.alu_src_a  = rdy;
                c.alu_src_b  = rdy ? 2'b10 : 2'b00;
                c.result_src = rdy ? 2'b10 : 2'b00;
            end
            DECODE: c.fault = cond_ex && op == OP_UND;
            EXECR, EXECI: begin
                c.alu_src_b = state_q == EXECI ? 2'b01 : 2'b00;
                c.fault     = !alu_ok;
                alu_out     = alu_ok ? alu_ctl : '0;
            end
            ALUWB: begin
                c.pc_write  = !is_cmp && rd == 4'hF;
                c.reg_write = !is_cmp && rd != 4'hF;
            end
            MEMADR: c.alu_src_b = 2'b01;
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = 2'b01;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = !timeout;
                c.adr_src   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
`ifdef MC_CTRL_BL_EN
                c.reg_write  = funct[4];
                c.link_sel   = funct[4];
`else
                c.link_sel   = 1'b0;
`endif
            end
            default: c.fault = 1'b0;
        endcase
        c.fault   = c.fault | timeout;
        c.imm_src = state_q == FETCH ? 2'b00 : op;
        c.reg_src = state_q == FETCH ? 2'b00 : {op == OP_MEM, op == OP_BR};
    end

    assign ctl            = RST ? '0 : c;
    assign bus.MemReq     = ctl.mem_req;
    assign bus.MemWrite   = ctl.mem_write;
    assign bus.AdrSrc     = ctl.adr_src;
    assign bus.IRWrite    = ctl.ir_write;
    assign bus.PCWrite    = ctl.pc_write;
    assign bus.RegWrite   = ctl.reg_write;
    assign bus.ResultSrc  = ctl.result_src;
    assign bus.ALUSrcA    = ctl.alu_src_a;
    assign bus.ALUSrcB    = ctl.alu_src_b;
    assign bus.ImmSrc     = ctl.imm_src;
    assign bus.RegSrc     = ctl.reg_src;
    assign bus.LinkSel    = ctl.link_sel;
    assign bus.Fault      = ctl.fault;
    assign bus.ALUControl = RST ? '0 : alu_out;
    assign bus.Flags      = RST ? '0 : flags_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors plus latency sequences for multicycle_controller.
module tb_multicycle_controller;
    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic [3:0]  af;
        logic        rdy;
        logic [19:0] exp;
        string       nm;
    } vec_t;

    localparam logic [31:0] ADD   = 32'hE0821003;
    localparam logic [31:0] SUBS  = 32'hE0521003;
    localparam logic [31:0] BEQ   = 32'h0A000002;
    localparam logic [31:0] BNE   = 32'h1A000002;
    localparam logic [31:0] LDR   = 32'hE5912000;
    localparam logic [31:0] STR   = 32'hE5812000;
    localparam logic [31:0] CMPS  = 32'hE1510002;
    localparam logic [31:0] EORI  = 32'hE2221003;
    localparam logic [31:0] ADDPC = 32'hE082F003;
    localparam logic [31:0] BAD   = 32'hE1E01003;
    localparam logic [31:0] UND   = 32'hEC000000;
    localparam logic [31:0] BL    = 32'hEB000004;
    localparam logic [31:0] B     = 32'hEA000002;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t v[$];

    always #5 CLK = ~CLK;

    mc_ctrl_if #(.ALUCTRL_W(3)) bus ();
    multicycle_controller #(.ALUCTRL_W(3), .MEM_TIMEOUT(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    function automatic logic [19:0] ex(input logic mq, mw, ad, ir, pw, rw, input logic [1:0] rs,
                                       input logic sa, input logic [1:0] sb, input logic [2:0] ac,
                                       input logic ls, f, input logic [3:0] fl);
        return {mq, mw, ad, ir, pw, rw, rs, sa, sb, ac, ls, f, fl};
    endfunction
    function automatic logic [19:0] fr(input logic [3:0] fl);
        return ex(1, 0, 0, 1, 1, 0, 2'b10, 1, 2'b10, 0, 0, 0, fl);
    endfunction
    function automatic logic [19:0] fw(input logic [3:0] fl);
        return ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, fl);
    endfunction
    function automatic logic [19:0] zz(input logic [3:0] fl);
        return ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, fl);
    endfunction
    function automatic logic [19:0] rw(input logic [3:0] fl);
        return ex(0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0, fl);
    endfunction
    function automatic logic [19:0] ma(input logic [3:0] fl);
        return ex(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 0, 0, fl);
    endfunction

    function automatic logic [19:0] act();
        return {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.LinkSel, bus.Fault, bus.Flags};
    endfunction

    function automatic void add(input logic r, input logic [31:0] i, input logic [3:0] a,
                                input logic d, input logic [19:0] e, input string n);
        vec_t t;
        t.rst = r; t.ins = i; t.af = a; t.rdy = d; t.exp = e; t.nm = n;
        v.push_back(t);
    endfunction

    task automatic check(input logic [31:0] a, input logic [31:0] e, input string nm);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic lat(input logic [31:0] ins, input int exp, input string nm);
        int n = 0;
        @(posedge CLK); #1;
        RST = 1'b1; bus.Instr = ins; bus.MemReady = 1'b1; bus.ALUFlags = 4'h0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check({31'd0, bus.IRWrite}, 32'd1, {nm, "_first_fetch"});
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.IRWrite && n < 20);
        check(n, exp, nm);
    endtask

    initial begin
        bus.Instr = '0; bus.ALUFlags = '0; bus.MemReady = 1'b0;
        add(1, ADD, 0, 1, zz(0), "reset");
        add(0, ADD, 0, 1, fr(0), "add_fetch");
        add(0, ADD, 0, 1, zz(0), "add_decode");
        add(0, ADD, 0, 1, zz(0), "add_execr");
        add(0, ADD, 0, 1, rw(0), "add_aluwb");
        add(0, SUBS, 0, 1, fr(0), "subs_fetch");
        add(0, SUBS, 0, 1, zz(0), "subs_decode");
        add(0, SUBS, 4'b0100, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "subs_execr");
        add(0, SUBS, 0, 1, rw(4'b0100), "subs_aluwb_flags");
        add(0, BEQ, 0, 1, fr(4), "beq_fetch");
        add(0, BEQ, 0, 1, zz(4), "beq_decode");
        add(0, BEQ, 0, 1, ex(0, 0, 0, 0, 1, 0, 2'b10, 1, 2'b01, 0, 0, 0, 4), "beq_branch");
        add(0, BNE, 0, 1, fr(4), "bne_fetch");
        add(0, BNE, 0, 1, zz(4), "bne_decode");
        add(0, LDR, 0, 1, fr(4), "bne_squashed_fetch");
        add(0, LDR, 0, 1, zz(4), "ldr_decode");
        add(0, LDR, 0, 1, ma(4), "ldr_memadr");
        for (int i = 0; i < 3; i++) add(0, LDR, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4), "ldr_wait");
        add(0, LDR, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4), "ldr_ready");
        add(0, LDR, 0, 1, ex(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 4), "ldr_memwb");
        add(0, STR, 0, 1, fr(4), "str_fetch");
        add(0, STR, 0, 1, zz(4), "str_decode");
        add(0, STR, 0, 1, ma(4), "str_memadr");
        add(0, STR, 0, 1, ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4), "str_memwrite");
        add(0, CMPS, 0, 1, fr(4), "cmp_fetch");
        add(0, CMPS, 0, 1, zz(4), "cmp_decode");
        add(0, CMPS, 4'b1000, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4), "cmp_execr");
        add(0, CMPS, 0, 1, zz(4'b1000), "cmp_aluwb_nowrite");
        add(0, EORI, 0, 1, fr(8), "eor_fetch");
        add(0, EORI, 0, 1, zz(8), "eor_decode");
        add(0, EORI, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 0, 8), "eor_execi");
        add(0, EORI, 0, 1, rw(8), "eor_aluwb");
        add(0, ADDPC, 0, 1, fr(8), "pc_fetch");
        add(0, ADDPC, 0, 1, zz(8), "pc_decode");
        add(0, ADDPC, 0, 1, zz(8), "pc_execr");
        add(0, ADDPC, 0, 1, ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8), "pc_aluwb");
        add(0, BAD, 0, 1, fr(8), "bad_fetch");
        add(0, BAD, 0, 1, zz(8), "bad_decode");
        add(0, BAD, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8), "bad_alu_fault");
        add(0, UND, 0, 1, fr(8), "und_fetch");
        add(0, UND, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8), "und_fault");
        add(0, BL, 0, 1, fr(8), "bl_fetch");
        add(0, BL, 0, 1, zz(8), "bl_decode");
`ifdef MC_CTRL_BL_EN
        add(0, BL, 0, 1, ex(0, 0, 0, 0, 1, 1, 2'b10, 1, 2'b01, 0, 1, 0, 8), "bl_branch_link");
`else
        add(0, BL, 0, 1, ex(0, 0, 0, 0, 1, 0, 2'b10, 1, 2'b01, 0, 0, 0, 8), "bl_branch_nolink");
`endif
        for (int i = 0; i < 4; i++) add(0, ADD, 0, 0, fw(8), "fetch_wait");
        add(0, ADD, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8), "fetch_timeout");
        for (int i = 0; i < 4; i++) add(0, ADD, 0, 0, fw(8), "fetch_retry_wait");
        add(0, ADD, 0, 1, fr(8), "ready_beats_timeout");
        add(0, ADD, 0, 1, zz(8), "retry_decode");
        add(0, ADD, 0, 1, zz(8), "retry_execr");
        add(0, ADD, 0, 1, rw(8), "retry_aluwb");
        add(0, STR, 0, 1, fr(8), "str2_fetch");
        add(0, STR, 0, 1, zz(8), "str2_decode");
        add(0, STR, 0, 1, ma(8), "str2_memadr");
        add(0, STR, 0, 0, ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8), "str2_wait");
        add(1, STR, 0, 0, zz(0), "rst_mid_store");
        add(0, STR, 0, 0, fw(0), "after_rst_fetch");
        add(0, BEQ, 0, 1, fr(0), "beq2_fetch");
        add(0, BEQ, 0, 1, zz(0), "beq2_decode");
        add(0, BEQ, 0, 1, fr(0), "beq2_squashed");
        foreach (v[i]) begin
            @(posedge CLK); #1;
            RST = v[i].rst; bus.Instr = v[i].ins; bus.ALUFlags = v[i].af; bus.MemReady = v[i].rdy;
            @(negedge CLK);
            check({12'd0, act()}, {12'd0, v[i].exp}, v[i].nm);
        end
        lat(ADD, 4, "lat_dp");
        lat(LDR, 5, "lat_ldr");
        lat(STR, 4, "lat_str");
        lat(B, 3, "lat_branch");
        lat(BEQ, 2, "lat_squash");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
